// File: rtl/paramest_nn_mul_pkg.sv
// Shared constants and narrowing helpers for the ParamEst NN multiplier.
package paramest_nn_mul_pkg;

   localparam int unsigned MAX_STAGE = 6;
   // Width of the internal arithmetic used by the narrowing helpers.
   localparam int unsigned CALC_W    = 64;
   // Largest product/result width the helpers can handle without overflow.
   localparam int unsigned MAX_OUT_W = 62;

   // Extended operands carry one extra MSB each; this width holds every product exactly.
   function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
      return w0 + w1 + 1;
   endfunction

   typedef struct packed {
      logic [CALC_W-1:0] value;
      logic              flag;
   } narrow_t;

   // Clamp p into the DOUT range; flag reports that the clamp fired.
   function automatic narrow_t clamp_narrow(input logic signed [CALC_W-1:0] p,
                                            input int unsigned dout_width,
                                            input logic signed_out);
      narrow_t                  r;
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      if (signed_out) begin
         hi = (64'sd1 <<< (dout_width - 1)) - 64'sd1;
         lo = -(64'sd1 <<< (dout_width - 1));
      end else begin
         hi = (64'sd1 <<< dout_width) - 64'sd1;
         lo = '0;
      end
      r.value = p;
      r.flag  = 1'b0;
      if (p > hi) begin
         r.value = hi;
         r.flag  = 1'b1;
      end else if (p < lo) begin
         r.value = lo;
         r.flag  = 1'b1;
      end
      return r;
   endfunction

   // Keep the low bits; flag when the dropped bits are not a pure extension.
   function automatic narrow_t wrap_narrow(input logic signed [CALC_W-1:0] p,
                                           input int unsigned dout_width,
                                           input logic signed_out);
      narrow_t                  r;
      logic signed [CALC_W-1:0] sext;
      sext    = (p <<< (CALC_W - dout_width)) >>> (CALC_W - dout_width);
      r.value = p;
      r.flag  = signed_out ? (sext != p) : ((p >>> dout_width) != '0);
      return r;
   endfunction

endpackage

// File: rtl/paramest_nn_mul_lane.sv
// One multiplier lane: extend, multiply, retime, shift and narrow.
module paramest_nn_mul_lane
   import paramest_nn_mul_pkg::*;
#(
   parameter int unsigned DIN0_WIDTH  = 16,
   parameter int unsigned DIN1_WIDTH  = 14,
   parameter int unsigned DOUT_WIDTH  = 29,
   parameter int unsigned NUM_STAGE   = 3,
   parameter bit          DIN0_SIGNED = 1'b0,
   parameter bit          DIN1_SIGNED = 1'b0,
   parameter bit          SATURATE    = 1'b0,
   parameter int unsigned SHIFT_W     = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [DIN0_WIDTH-1:0] a_i,
   input  logic [DIN1_WIDTH-1:0] b_i,
   input  logic [SHIFT_W-1:0]    shift_i,
   output logic [DOUT_WIDTH-1:0] dout_o,
   output logic                  sat_o
);

   localparam int unsigned PW         = prod_width(DIN0_WIDTH, DIN1_WIDTH);
   localparam int unsigned RETIME     = (NUM_STAGE >= 2) ? NUM_STAGE - 2 : 0;
   localparam logic        SIGNED_OUT = DIN0_SIGNED || DIN1_SIGNED;

   logic [DIN0_WIDTH-1:0] a_s;
   logic [DIN1_WIDTH-1:0] b_s;
   logic [SHIFT_W-1:0]    sh_s;

   if (NUM_STAGE >= 2) begin : g_in_reg
      logic [DIN0_WIDTH-1:0] a_q;
      logic [DIN1_WIDTH-1:0] b_q;
      logic [SHIFT_W-1:0]    sh_q;
      // First stage captures the operands and the shift amount.
      always_ff @(posedge clk_i) begin
         if (en_i) begin
            a_q  <= a_i;
            b_q  <= b_i;
            sh_q <= shift_i;
         end
      end
      assign a_s  = a_q;
      assign b_s  = b_q;
      assign sh_s = sh_q;
   end else begin : g_in_comb
      assign a_s  = a_i;
      assign b_s  = b_i;
      assign sh_s = shift_i;
   end

   logic signed [PW-1:0] a_x;
   logic signed [PW-1:0] b_x;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] p_end;
   logic [SHIFT_W-1:0]   s_end;

   assign a_x  = {{(PW - DIN0_WIDTH){DIN0_SIGNED & a_s[DIN0_WIDTH-1]}}, a_s};
   assign b_x  = {{(PW - DIN1_WIDTH){DIN1_SIGNED & b_s[DIN1_WIDTH-1]}}, b_s};
   assign prod = a_x * b_x;

   if (RETIME > 0) begin : g_retime
      logic signed [PW-1:0] p_q [RETIME];
      logic [SHIFT_W-1:0]   s_q [RETIME];
      // Middle stages carry the product and shift forward as retiming registers.
      always_ff @(posedge clk_i) begin
         if (en_i) begin
            p_q[0] <= prod;
            s_q[0] <= sh_s;
            for (int i = 1; i < int'(RETIME); i++) begin
               p_q[i] <= p_q[i-1];
               s_q[i] <= s_q[i-1];
            end
         end
      end
      assign p_end = p_q[RETIME-1];
      assign s_end = s_q[RETIME-1];
   end else begin : g_no_retime
      assign p_end = prod;
      assign s_end = sh_s;
   end

   logic signed [PW-1:0]     shifted;
   logic signed [CALC_W-1:0] p_wide;
   narrow_t                  nr;
   logic                     unused_hi;

   assign shifted = p_end >>> s_end;
   assign p_wide  = {{(CALC_W - PW){shifted[PW-1]}}, shifted};

   // Narrow the shifted product to the output width, clamping or wrapping.
   always_comb begin
      nr = SATURATE ? clamp_narrow(p_wide, DOUT_WIDTH, SIGNED_OUT)
                    : wrap_narrow(p_wide, DOUT_WIDTH, SIGNED_OUT);
   end

   assign unused_hi = ^nr.value[CALC_W-1:DOUT_WIDTH];

   logic [DOUT_WIDTH-1:0] dout_q;
   logic                  sat_q;

   // Final stage registers the narrowed result and its overflow flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dout_q <= '0;
         sat_q  <= 1'b0;
      end else if (en_i) begin
         dout_q <= nr.value[DOUT_WIDTH-1:0];
         sat_q  <= nr.flag;
      end
   end

   assign dout_o = dout_q;
   assign sat_o  = sat_q;

endmodule

// File: rtl/paramest_nn_mul_pipe.sv
// Pipelined multi-lane multiplier with a single valid/ready handshake.
module paramest_nn_mul_pipe
   import paramest_nn_mul_pkg::*;
#(
   parameter int unsigned LANES       = 4,
   parameter int unsigned DIN0_WIDTH  = 16,
   parameter int unsigned DIN1_WIDTH  = 14,
   parameter int unsigned DOUT_WIDTH  = 29,
   parameter int unsigned NUM_STAGE   = 3,
   parameter bit          DIN0_SIGNED = 1'b0,
   parameter bit          DIN1_SIGNED = 1'b0,
   parameter bit          SATURATE    = 1'b0,
   parameter int unsigned SHIFT_W     = 5
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DIN0_WIDTH-1:0] din0,
   input  logic [LANES*DIN1_WIDTH-1:0] din1,
   input  logic [SHIFT_W-1:0]          shift,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DOUT_WIDTH-1:0] dout,
   output logic [LANES-1:0]            sat
);

   if (NUM_STAGE < 1 || NUM_STAGE > MAX_STAGE) begin : g_bad_stage
      $fatal(1, "paramest_nn_mul_pipe: NUM_STAGE must be in 1..6");
   end
   if (DOUT_WIDTH < 1 || DOUT_WIDTH > MAX_OUT_W) begin : g_bad_dout
      $fatal(1, "paramest_nn_mul_pipe: DOUT_WIDTH out of range");
   end
   if (prod_width(DIN0_WIDTH, DIN1_WIDTH) > MAX_OUT_W) begin : g_bad_prod
      $fatal(1, "paramest_nn_mul_pipe: operand widths too large");
   end

   logic                 adv;
   logic [NUM_STAGE-1:0] vld_q;
   logic [NUM_STAGE-1:0] vld_d;

   // The whole pipe moves together whenever the output slot is free or being drained.
   assign out_valid = vld_q[NUM_STAGE-1];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   // Next state of the valid chain: shift on advance, bubbles enter as 0.
   always_comb begin
      vld_d = vld_q;
      if (adv) begin
         vld_d[0] = in_valid;
         for (int i = 1; i < int'(NUM_STAGE); i++) begin
            vld_d[i] = vld_q[i-1];
         end
      end
   end

   // Valid chain register; reset discards every in-flight beat.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
      paramest_nn_mul_lane #(
         .DIN0_WIDTH  (DIN0_WIDTH),
         .DIN1_WIDTH  (DIN1_WIDTH),
         .DOUT_WIDTH  (DOUT_WIDTH),
         .NUM_STAGE   (NUM_STAGE),
         .DIN0_SIGNED (DIN0_SIGNED),
         .DIN1_SIGNED (DIN1_SIGNED),
         .SATURATE    (SATURATE),
         .SHIFT_W     (SHIFT_W)
      ) u_lane (
         .clk_i   (ap_clk),
         .rst_i   (ap_rst),
         .en_i    (adv),
         .a_i     (din0[l*DIN0_WIDTH +: DIN0_WIDTH]),
         .b_i     (din1[l*DIN1_WIDTH +: DIN1_WIDTH]),
         .shift_i (shift),
         .dout_o  (dout[l*DOUT_WIDTH +: DOUT_WIDTH]),
         .sat_o   (sat[l])
      );
   end

endmodule
